// File: rtl/encoder_decimal_to_bcd_keypad.sv
// Decimal keypad to BCD encoder: synchronizes and debounces ten key lines, emits a
// one-cycle strobe per accepted key, shifts digits into a BCD buffer, flags multi-key presses.
module encoder_decimal_to_bcd_keypad #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            in,
  input  logic                  clear,
  output logic [3:0]            out,
  output logic                  valid,
  output logic                  multi,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t                state;
  logic [9:0]            sync1;
  logic [9:0]            sync2;
  logic [9:0]            candidate;
  logic [3:0]            code;
  logic [CW-1:0]         cnt;

  logic                  s2_many;
  logic                  s2_onehot;
  logic [3:0]            s2_code;
  logic [4*DIGITS-1:0]   digits_base;
  logic [4*DIGITS+3:0]   digits_shift;

  always_comb begin
    s2_many   = |(sync2 & (sync2 - 10'd1));
    s2_onehot = (sync2 != 10'd0) && !s2_many;
    s2_code   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sync2[i]) s2_code = 4'(i);
    end
    // Clear applies before the insert when both land on the same edge.
    digits_base  = clear ? '0 : digits;
    digits_shift = {digits_base, code};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      code      <= '0;
      cnt       <= '0;
      out       <= '0;
      valid     <= 1'b0;
      multi     <= 1'b0;
      digits    <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      valid <= 1'b0;

      if (clear) begin
        digits <= '0;
        multi  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s2_onehot) begin
            candidate <= sync2;
            code      <= s2_code;
            cnt       <= CW'(1);
            state     <= DEBOUNCE;
          end else if (s2_many && !clear) begin
            multi <= 1'b1;
          end
        end

        DEBOUNCE: begin
          if (sync2 == candidate) begin
            if (cnt == CNT_LAST) begin
              out    <= code;
              valid  <= 1'b1;
              digits <= digits_shift[4*DIGITS-1:0];
              cnt    <= '0;
              state  <= HELD;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            if (s2_many && !clear) multi <= 1'b1;
            state <= IDLE;
          end
        end

        HELD: begin
          // Any key activity restarts the release count; extra keys are ignored here.
          if (sync2 == 10'd0) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_decimal_to_bcd_keypad.sv
// Directed bench for the keypad encoder: table of press/release vectors plus
// hand-written sequences for glitches, multi-key, clear and reset corners.
module tb_encoder_decimal_to_bcd_keypad;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  in;
  logic        clear;
  logic [3:0]  out;
  logic        valid;
  logic        multi;
  logic [15:0] digits;

  encoder_decimal_to_bcd_keypad #(.DEBOUNCE_CYCLES(4), .DIGITS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .clear  (clear),
    .out    (out),
    .valid  (valid),
    .multi  (multi),
    .digits (digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  keys;
    int          hold;
    int          rel;
    int          exp_valids;
    logic [3:0]  exp_out;
    logic [15:0] exp_digits;
    logic        exp_multi;
  } vec_t;

  vec_t vecs[7];

  int pass_cnt = 0;
  int total    = 0;
  int edge_n   = 0;
  int vcount   = 0;
  int last_valid_edge = -1;

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (valid) begin
      vcount++;
      last_valid_edge = edge_n;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int start;
    int v0;
    int r;

    vecs[0] = '{10'b00_0010_0000, 20, 12, 1, 4'd5, 16'h0005, 1'b0};
    vecs[1] = '{10'b00_0000_0010, 12, 12, 1, 4'd1, 16'h0051, 1'b0};
    vecs[2] = '{10'b10_0000_0000, 12, 12, 1, 4'd9, 16'h0519, 1'b0};
    vecs[3] = '{10'b00_0000_0001, 12, 12, 1, 4'd0, 16'h5190, 1'b0};
    vecs[4] = '{10'b00_0000_1000, 12, 12, 1, 4'd3, 16'h1903, 1'b0};
    vecs[5] = '{10'b00_1000_0000, 12, 12, 1, 4'd7, 16'h9037, 1'b0};
    vecs[6] = '{10'b00_0000_0100,  3, 12, 0, 4'd7, 16'h9037, 1'b0};

    reset = 1'b1;
    in    = '0;
    clear = 1'b0;
    repeat (3) tick();
    check("reset_out",    {12'd0, out},   16'h0000);
    check("reset_valid",  {15'd0, valid}, 16'h0000);
    check("reset_multi",  {15'd0, multi}, 16'h0000);
    check("reset_digits", digits,         16'h0000);
    reset = 1'b0;
    tick();
    vcount = 0;

    for (int i = 0; i < 7; i++) begin
      start = edge_n;
      v0    = vcount;
      in    = vecs[i].keys;
      repeat (vecs[i].hold) tick();
      in = '0;
      repeat (vecs[i].rel) tick();
      $display("vec %0d keys=%b valids=%0d out=%0d digits=%h multi=%0b",
               i, vecs[i].keys, vcount - v0, out, digits, multi);
      check($sformatf("vec%0d_valids", i), 16'(vcount - v0), 16'(vecs[i].exp_valids));
      check($sformatf("vec%0d_out", i),    {12'd0, out},    {12'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_digits", i), digits,          vecs[i].exp_digits);
      check($sformatf("vec%0d_multi", i),  {15'd0, multi},  {15'd0, vecs[i].exp_multi});
      if (vecs[i].exp_valids == 1)
        check($sformatf("vec%0d_latency", i), 16'(last_valid_edge), 16'(start + 6));
    end

    // Key 8 toggling every cycle never survives debounce.
    v0 = vcount;
    for (int i = 0; i < 10; i++) begin
      in = (i % 2 == 0) ? 10'b01_0000_0000 : 10'd0;
      tick();
    end
    in = '0;
    repeat (12) tick();
    $display("glitch8 valids=%0d out=%0d digits=%h multi=%0b", vcount - v0, out, digits, multi);
    check("glitch_valids", 16'(vcount - v0), 16'd0);
    check("glitch_out",    {12'd0, out},     16'd7);
    check("glitch_digits", digits,           16'h9037);
    check("glitch_multi",  {15'd0, multi},   16'd0);

    // Keys 4 and 6 together: multi appears the cycle after detection.
    v0 = vcount;
    in = 10'b00_0101_0000;
    repeat (2) tick();
    check("multi_early", {15'd0, multi}, 16'd0);
    tick();
    check("multi_set", {15'd0, multi}, 16'd1);
    repeat (7) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("multi_clear_wins", {15'd0, multi}, 16'd0);
    in = '0;
    repeat (12) tick();
    check("multi_resticky", {15'd0, multi}, 16'd1);
    check("multi_valids",   16'(vcount - v0), 16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    $display("multi46 multi=%0b digits=%h", multi, digits);
    check("clear_multi",  {15'd0, multi}, 16'd0);
    check("clear_digits", digits,         16'h0000);

    // Key 3 accepted, then key 7 added while held: ignored.
    v0 = vcount;
    in = 10'b00_0000_1000;
    repeat (10) tick();
    check("k3_valids", 16'(vcount - v0), 16'd1);
    check("k3_digits", digits, 16'h0003);
    in = 10'b00_1000_1000;
    repeat (12) tick();
    check("k3k7_valids", 16'(vcount - v0), 16'd1);
    check("k3k7_multi",  {15'd0, multi}, 16'd0);
    in = '0;
    repeat (12) tick();
    start = edge_n;
    in = 10'b00_1000_0000;
    repeat (10) tick();
    in = '0;
    repeat (12) tick();
    $display("k3_then_k7 out=%0d digits=%h", out, digits);
    check("k7_valids",  16'(vcount - v0), 16'd2);
    check("k7_out",     {12'd0, out}, 16'd7);
    check("k7_digits",  digits, 16'h0037);
    check("k7_latency", 16'(last_valid_edge), 16'(start + 6));

    // Reset in the middle of debouncing key 9, key kept held.
    v0 = vcount;
    in = 10'b10_0000_0000;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("rst_mid_out",    {12'd0, out}, 16'd0);
    check("rst_mid_digits", digits, 16'h0000);
    r = edge_n;
    reset = 1'b0;
    repeat (5) tick();
    check("rst_no_valid", 16'(vcount - v0), 16'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    $display("reset_k9 valid=%0b out=%0d digits=%h", valid, out, digits);
    check("rst_valid",   {15'd0, valid}, 16'd1);
    check("rst_out",     {12'd0, out}, 16'd9);
    check("rst_digits",  digits, 16'h0009);
    check("rst_latency", 16'(last_valid_edge), 16'(r + 6));
    in = '0;
    repeat (12) tick();

    // Clear on an acceptance edge with a non-empty buffer: clear then insert.
    start = edge_n;
    in = 10'b00_0001_0000;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    $display("clear_on_accept valid=%0b out=%0d digits=%h", valid, out, digits);
    check("coa_valid",   {15'd0, valid}, 16'd1);
    check("coa_digits",  digits, 16'h0004);
    check("coa_latency", 16'(last_valid_edge), 16'(start + 6));
    tick();
    check("coa_pulse_width", {15'd0, valid}, 16'd0);
    in = '0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
